// File: rtl/mdu_pkg.sv
// Op codes, counter width and decode helpers shared by the multiply/divide unit.
// Optional macro MDU_MADD_EN enables the multiply-accumulate op codes.
package mdu_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  // Multi-cycle ops: these set Busy and commit through the pending register.
  function automatic logic is_muldiv(input mdu_op_e op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_muldiv = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB:         is_muldiv = 1'b1;
`endif
      default:                            is_muldiv = 1'b0;
    endcase
  endfunction

  function automatic logic is_div(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mdu(input mdu_op_e op);
    return is_muldiv(op) || (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result path: 64-bit {HI,LO} result for a mult/div op plus divide-by-zero flag.
// Optional macro MDU_MADD_EN adds the accumulate forms built on acc_i.
module mdu_calc
  import mdu_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [63:0] acc_i,
  output logic [63:0] res_o,
  output logic        div0_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvsr;
  logic [31:0] quo_u;
  logic [31:0] rem_u;

`ifndef MDU_MADD_EN
  logic unused_acc;
  assign unused_acc = ^acc_i;
`endif

  always_comb begin
    // Low 64 bits of a 64x64 product of the extended operands are the exact 32x32 result.
    prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    prod_u = {32'd0, a_i} * {32'd0, b_i};

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    neg_a  = (op_i == OP_DIV) && a_i[31];
    neg_b  = (op_i == OP_DIV) && b_i[31];
    mag_a  = neg_a ? -a_i : a_i;
    mag_b  = neg_b ? -b_i : b_i;
    dvsr   = (b_i == 32'd0) ? 32'd1 : mag_b;
    quo_u  = mag_a / dvsr;
    rem_u  = mag_a % dvsr;
    div0_o = is_div(op_i) && (b_i == 32'd0);

    res_o = '0;
    case (op_i)
      OP_MULT:         res_o = prod_s;
      OP_MULTU:        res_o = prod_u;
      OP_DIV, OP_DIVU: res_o = {(neg_a ? -rem_u : rem_u),
                                ((neg_a ^ neg_b) ? -quo_u : quo_u)};
`ifdef MDU_MADD_EN
      OP_MADD:         res_o = acc_i + prod_s;
      OP_MADDU:        res_o = acc_i + prod_u;
      OP_MSUB:         res_o = acc_i - prod_s;
`endif
      default:         res_o = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: HI/LO registers, fixed-latency busy counter, mthi/mtlo.
// Optional macro MDU_MADD_EN enables madd/maddu/msub (decoded in mdu_pkg, computed in mdu_calc).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        MDUClass,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      pend_q, pend_d;
  logic             dz_q, dz_d;

  mdu_op_e          op;
  logic             accept;
  logic [63:0]      calc_res;
  logic             calc_div0;

  assign op       = mdu_op_e'(MDUOp);
  assign accept   = Start && (state_q == S_IDLE);
  assign MDUClass = Start && is_mdu(op);
  assign Busy     = (state_q == S_RUN);
  assign HI       = hi_q;
  assign LO       = lo_q;

  mdu_calc u_calc (
    .op_i   (op),
    .a_i    (A),
    .b_i    (B),
    .acc_i  ({hi_q, lo_q}),
    .res_o  (calc_res),
    .div0_o (calc_div0)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_muldiv(op)) begin
            pend_d  = calc_res;
            dz_d    = calc_div0;
            cnt_d   = is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d = S_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = A;
          end else if (op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Commit on the same edge Busy falls; a zero divisor leaves HI/LO untouched.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (!dz_q) begin
            {hi_d, lo_d} = pend_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops against an arithmetic model.
// Honours MDU_MADD_EN the same way the design does.
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        MDUClass;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_hi;
  logic [31:0] ref_lo;

  always #5 clk = ~clk;

  mult_div_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .MDUOp    (MDUOp),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .MDUClass (MDUClass),
    .HI       (HI),
    .LO       (LO)
  );

  function automatic logic op_known(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1) && (op <= 4'd9);
`else
    return (op >= 4'd1) && (op <= 4'd6);
`endif
  endfunction

  // Architectural effect of one accepted op on ref_hi/ref_lo; returns the busy latency.
  function automatic int model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, acc, res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {ref_hi, ref_lo};
    if (!op_known(op)) return 0;
    case (op)
      4'd1: begin res = sa * sb; {ref_hi, ref_lo} = res; return MULT_N; end
      4'd2: begin res = ua * ub; {ref_hi, ref_lo} = res; return MULT_N; end
      4'd3: begin
        if (b != 32'd0) begin
          q = sa / sb;
          r = sa % sb;
          ref_lo = q[31:0];
          ref_hi = r[31:0];
        end
        return DIV_N;
      end
      4'd4: begin
        if (b != 32'd0) begin
          res = ua / ub; ref_lo = res[31:0];
          res = ua % ub; ref_hi = res[31:0];
        end
        return DIV_N;
      end
      4'd5: begin ref_hi = a; return 0; end
      4'd6: begin ref_lo = a; return 0; end
      4'd7: begin res = acc + 64'(sa * sb); {ref_hi, ref_lo} = res; return MULT_N; end
      4'd8: begin res = acc + ua * ub;      {ref_hi, ref_lo} = res; return MULT_N; end
      4'd9: begin res = acc - 64'(sa * sb); {ref_hi, ref_lo} = res; return MULT_N; end
      default: return 0;
    endcase
  endfunction

  // Called at a falling edge; leaves at the next falling edge with Start dropped.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic cls);
    Start = 1'b1;
    MDUOp = op;
    A     = a;
    B     = b;
    #1 cls = MDUClass;
    @(negedge clk);
    Start = 1'b0;
    MDUOp = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic cls;
    reset = 1'b1; Start = 1'b0; MDUOp = 4'd0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", Busy); end
    total++; if (HI !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", HI); end
    total++; if (LO !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", LO); end
    reset = 1'b0;
    ref_hi = '0; ref_lo = '0;
    MDUOp = 4'd1;
    #1 cls = MDUClass;
    total++; if (cls !== 1'b0) begin bad++; $display("FAIL class_no_start got=%0b exp=0", cls); end
    MDUOp = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    logic cls;
    int   n, lat;
    lat = model_exec(4'd1, 32'hFFFF_FFFE, 32'd3);
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, cls);
    total++; if (LO !== 32'd0) begin bad++; $display("FAIL mult_no_partial got=%h exp=0", LO); end
    wait_idle(n);
    total++; if (n != 5) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
    total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
    total++; if (LO !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffa", LO); end
    lat = model_exec(4'd2, 32'hFFFF_FFFE, 32'd3);
    issue(4'd2, 32'hFFFF_FFFE, 32'd3, cls);
    wait_idle(n);
    total++; if (HI !== 32'h0000_0002) begin bad++; $display("FAIL multu_hi got=%h exp=00000002", HI); end
    total++; if (LO !== 32'hFFFF_FFFA) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffa", LO); end
  endtask

  task automatic test_div;
    logic cls;
    int   n, lat;
    lat = model_exec(4'd3, 32'hFFFF_FFF9, 32'd2);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, cls);
    wait_idle(n);
    total++; if (n != 10) begin bad++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
    total++; if (LO !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
    total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
    lat = model_exec(4'd4, 32'd7, 32'd2);
    issue(4'd4, 32'd7, 32'd2, cls);
    wait_idle(n);
    total++; if (LO !== 32'd3) begin bad++; $display("FAIL divu_lo got=%h exp=3", LO); end
    total++; if (HI !== 32'd1) begin bad++; $display("FAIL divu_hi got=%h exp=1", HI); end
    lat = model_exec(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cls);
    wait_idle(n);
    total++; if (LO !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo got=%h exp=80000000", LO); end
    total++; if (HI !== 32'd0) begin bad++; $display("FAIL div_ovf_hi got=%h exp=0", HI); end
  endtask

  task automatic test_div_zero;
    logic cls;
    int   n, lat;
    lat = model_exec(4'd5, 32'h11, 32'd0);
    issue(4'd5, 32'h11, 32'd0, cls);
    lat = model_exec(4'd6, 32'h22, 32'd0);
    issue(4'd6, 32'h22, 32'd0, cls);
    lat = model_exec(4'd4, 32'd5, 32'd0);
    issue(4'd4, 32'd5, 32'd0, cls);
    wait_idle(n);
    total++; if (n != 10) begin bad++; $display("FAIL div0_busy_cycles got=%0d exp=10", n); end
    total++; if (HI !== 32'h11) begin bad++; $display("FAIL div0_hi got=%h exp=11", HI); end
    total++; if (LO !== 32'h22) begin bad++; $display("FAIL div0_lo got=%h exp=22", LO); end
  endtask

  task automatic test_ignore_busy;
    logic cls;
    int   n, lat;
    lat = model_exec(4'd2, 32'd1234, 32'd5678);
    issue(4'd2, 32'd1234, 32'd5678, cls);
    issue(4'd6, 32'h55, 32'd0, cls);
    total++; if (cls !== 1'b1) begin bad++; $display("FAIL busy_class got=%0b exp=1", cls); end
    wait_idle(n);
    total++; if (n + 1 != 5) begin bad++; $display("FAIL busy_mult_cycles got=%0d exp=5", n + 1); end
    total++; if (LO !== 32'd7006652) begin bad++; $display("FAIL busy_mtlo_ignored got=%h exp=%h", LO, 32'd7006652); end
    lat = model_exec(4'd5, 32'hABCD, 32'd0);
    issue(4'd5, 32'hABCD, 32'd0, cls);
    total++; if (HI !== 32'hABCD) begin bad++; $display("FAIL mthi_hi got=%h exp=0000abcd", HI); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%0b exp=0", Busy); end
    total++; if (LO !== 32'd7006652) begin bad++; $display("FAIL mthi_lo_kept got=%h exp=%h", LO, 32'd7006652); end
  endtask

  task automatic test_reset_abort;
    logic cls;
    issue(4'd4, 32'd100, 32'd7, cls);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b exp=0", Busy); end
    total++; if ({HI, LO} !== 64'd0) begin bad++; $display("FAIL abort_hilo got=%h exp=0", {HI, LO}); end
    repeat (12) @(negedge clk);
    total++; if ({HI, LO} !== 64'd0) begin bad++; $display("FAIL abort_no_commit got=%h exp=0", {HI, LO}); end
    ref_hi = '0; ref_lo = '0;
  endtask

  task automatic test_madd;
    logic cls;
    int   n, lat;
    lat = model_exec(4'd5, 32'd0, 32'd0);
    issue(4'd5, 32'd0, 32'd0, cls);
    lat = model_exec(4'd6, 32'd1, 32'd0);
    issue(4'd6, 32'd1, 32'd0, cls);
    lat = model_exec(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cls);
    wait_idle(n);
`ifdef MDU_MADD_EN
    total++; if (cls !== 1'b1) begin bad++; $display("FAIL maddu_class got=%0b exp=1", cls); end
    total++; if (n != 5) begin bad++; $display("FAIL maddu_cycles got=%0d exp=5", n); end
    total++; if (HI !== 32'hFFFF_FFFE) begin bad++; $display("FAIL maddu_hi got=%h exp=fffffffe", HI); end
    total++; if (LO !== 32'h0000_0002) begin bad++; $display("FAIL maddu_lo got=%h exp=00000002", LO); end
`else
    total++; if (cls !== 1'b0) begin bad++; $display("FAIL maddu_off_class got=%0b exp=0", cls); end
    total++; if (n != 0) begin bad++; $display("FAIL maddu_off_cycles got=%0d exp=0", n); end
    total++; if (HI !== 32'd0) begin bad++; $display("FAIL maddu_off_hi got=%h exp=0", HI); end
    total++; if (LO !== 32'd1) begin bad++; $display("FAIL maddu_off_lo got=%h exp=1", LO); end
`endif
  endtask

  // Back-to-back random ops: each issues on the first idle cycle after the previous one.
  task automatic test_random;
    logic        cls, exp_cls;
    logic [3:0]  op;
    logic [31:0] a, b;
    int          n, lat;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      exp_cls = op_known(op);
      lat     = model_exec(op, a, b);
      issue(op, a, b, cls);
      wait_idle(n);
      total++; if (cls !== exp_cls) begin bad++; $display("FAIL rnd_class op=%0d got=%0b exp=%0b", op, cls, exp_cls); end
      total++; if (n != lat) begin bad++; $display("FAIL rnd_cycles op=%0d got=%0d exp=%0d", op, n, lat); end
      total++; if (HI !== ref_hi) begin bad++; $display("FAIL rnd_hi op=%0d a=%h b=%h got=%h exp=%h", op, a, b, HI, ref_hi); end
      total++; if (LO !== ref_lo) begin bad++; $display("FAIL rnd_lo op=%0d a=%h b=%h got=%h exp=%h", op, a, b, LO, ref_lo); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_busy();
    test_reset_abort();
    test_madd();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
